ysyx_25010008_sram: RTL

YSYX_25010008_SRAM -- requirements
Module: ysyx_25010008_SRAM

---
 rtl/ysyx_25010008_sram.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_25010008_sram.sv
// AXI4-lite SRAM slave that serves one transaction at a time with a programmable access delay.
// Define SRAM_RAND_DELAY_EN to replace the fixed LATENCY with an LFSR-driven delay of 1..4 cycles.
module ysyx_25010008_sram #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_DATA, W_WAIT, B_RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        delay;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       mem [DEPTH_WORDS];
  logic              ar_hs, aw_hs, w_hs;
  logic              wait_done;
  logic [31:0]       word_off;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;

  assign ar_hs     = arvalid && arready;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign wait_done = (cnt == 4'd1);

  // Word offset compared as a whole so addresses beyond the top can never alias onto low words.
  assign word_off = (addr_q - ADDR_BASE) >> 2;
  assign in_range = (addr_q >= ADDR_BASE) && (word_off < 32'(DEPTH_WORDS));
  assign idx      = word_off[IDX_W-1:0];
  assign mem_we   = (state == W_WAIT) && wait_done && in_range;

`ifdef SRAM_RAND_DELAY_EN
  logic [3:0] lfsr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= 4'b1001;
    end else if (ar_hs || w_hs) begin
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
  end

  assign delay = 4'd1 + {2'b00, lfsr[1:0]};
`else
  assign delay = 4'(LATENCY);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    rvalid    = 1'b0;
    bvalid    = 1'b0;
    case (state)
      IDLE: begin
        awready = 1'b1;
        arready = !awvalid;
        if (awvalid) begin
          state_nxt = W_DATA;
        end else if (arvalid) begin
          state_nxt = R_WAIT;
        end
      end
      R_WAIT: if (wait_done) state_nxt = R_RESP;
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) state_nxt = IDLE;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) state_nxt = W_WAIT;
      end
      W_WAIT: if (wait_done) state_nxt = B_RESP;
      B_RESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Delay counter and response registers; responses latch on the last wait cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= 4'd0;
      rdata <= 32'd0;
      rresp <= RESP_OKAY;
      bresp <= RESP_OKAY;
    end else begin
      if (ar_hs || w_hs) begin
        cnt <= delay;
      end else if (state == R_WAIT || state == W_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == R_WAIT && wait_done) begin
        rdata <= in_range ? mem[idx] : 32'd0;
        rresp <= in_range ? RESP_OKAY : RESP_DECERR;
      end
      if (state == W_WAIT && wait_done) begin
        bresp <= in_range ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ar_hs) begin
      addr_q <= araddr;
    end else if (aw_hs) begin
      addr_q <= awaddr;
    end
    if (w_hs) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // Storage has no reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
